wb_stage: RTL and testbench

//  MEM/WB pipeline register and write-back unit of the MIPS core; directly upstream of the register file.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/wb_stage_load_align.sv | 29 ++
 rtl/wb_stage.sv | 130 +++++++++++++
 tb/tb_wb_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the MEM/WB stage payload.
// Contents: XLEN, register-index width, REGDST_*/WBSEL_*/LD_* encodings,
//           REG_RA ($31), and wb_entry_t (fields captured by wb_stage).
package mips_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_PC4  = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    // Everything the MEM stage hands over for write-back.
    typedef struct packed {
        logic             reg_write;
        logic [1:0]       reg_dst;
        logic [1:0]       wb_sel;
        logic [2:0]       load_type;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  mem_rdata;
        logic [XLEN-1:0]  pc_plus4;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: little-endian byte/half extraction and extension of a load word.
// Ports: mem_rdata_i (read word), off_i (byte offset), load_type_i (LD_*),
//        data_o (extended 32-bit result, combinational).
module load_align
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      load_type_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(mem_rdata_i >> {off_i, 3'b000});
        // Halfword offset uses only off[1]; misaligned low bit is ignored.
        half_v = off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (load_type_i)
            LD_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data_o = {24'd0, byte_v};
            LD_LH:   data_o = {{16{half_v[15]}}, half_v};
            LD_LHU:  data_o = {16'd0, half_v};
            default: data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and register-file write-back unit.
// Captures MEM results, selects write data (ALU / aligned load / PC+4) and
// destination (rt / rd / $31), drives the RF write port once per instruction
// and counts retired instructions.
// Ports: clk, rst (sync, active high); in_valid/stall/flush control; MEM
//        fields (reg_write_in, reg_dst, wb_sel, load_type, rt, rd, alu_result,
//        mem_rdata, pc_plus4); decode RF reads (read_reg1/2, rf_data1/2);
//        outputs reg_write, write_reg, write_data, fwd_data1/2, wb_valid,
//        retired_cnt.
// Config: WB_BYPASS_EN enables write-through forwarding onto fwd_data1/2.
module wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              reg_write_in,
    input  logic [1:0]        reg_dst,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        load_type,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [REG_W-1:0]  read_reg1,
    input  logic [REG_W-1:0]  read_reg2,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    output logic              reg_write,
    output logic [REG_W-1:0]  write_reg,
    output logic [XLEN-1:0]   write_data,
    output logic [XLEN-1:0]   fwd_data1,
    output logic [XLEN-1:0]   fwd_data2,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retired_cnt
);

    wb_entry_t        entry_q, entry_d;
    logic             valid_q, valid_d;
    logic             fired_q, fired_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  load_data;

    // Next-state: retire bookkeeping, then capture (flush beats stall).
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        fired_d = fired_q;
        cnt_d   = cnt_q;
        if (valid_q && !fired_q && !flush) begin
            fired_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            entry_d.reg_write  = reg_write_in;
            entry_d.reg_dst    = reg_dst;
            entry_d.wb_sel     = wb_sel;
            entry_d.load_type  = load_type;
            entry_d.rt         = rt;
            entry_d.rd         = rd;
            entry_d.alu_result = alu_result;
            entry_d.mem_rdata  = mem_rdata;
            entry_d.pc_plus4   = pc_plus4;
            valid_d            = in_valid;
            fired_d            = 1'b0;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            valid_q <= 1'b0;
            fired_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            fired_q <= fired_d;
            cnt_q   <= cnt_d;
        end
    end

    load_align u_load_align (
        .mem_rdata_i (entry_q.mem_rdata),
        .off_i       (entry_q.alu_result[1:0]),
        .load_type_i (entry_q.load_type),
        .data_o      (load_data)
    );

    // Destination and data select from the captured entry.
    always_comb begin
        case (entry_q.reg_dst)
            REGDST_RD: write_reg = entry_q.rd;
            REGDST_RA: write_reg = REG_RA;
            default:   write_reg = entry_q.rt;
        endcase
        case (entry_q.wb_sel)
            WBSEL_LOAD: write_data = load_data;
            WBSEL_PC4:  write_data = entry_q.pc_plus4;
            default:    write_data = entry_q.alu_result;
        endcase
        // fired_q blocks repeat writes while the entry is held by a stall.
        reg_write = valid_q && entry_q.reg_write && !fired_q && (write_reg != '0);
    end

`ifdef WB_BYPASS_EN
    // Write-through: decode sees the value being committed this cycle.
    always_comb begin
        fwd_data1 = (reg_write && (read_reg1 == write_reg)) ? write_data : rf_data1;
        fwd_data2 = (reg_write && (read_reg2 == write_reg)) ? write_data : rf_data2;
    end
`else
    logic unused_read_regs;
    assign unused_read_regs = ^{read_reg1, read_reg2};
    assign fwd_data1 = rf_data1;
    assign fwd_data2 = rf_data2;
`endif

    assign wb_valid    = valid_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected RF writes, a
// negedge monitor pops one per reg_write pulse and compares.
module tb_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, reg_write_in;
    logic [1:0]  reg_dst, wb_sel;
    logic [2:0]  load_type;
    logic [4:0]  rt, rd, read_reg1, read_reg2;
    logic [31:0] alu_result, mem_rdata, pc_plus4, rf_data1, rf_data2;
    logic        reg_write, wb_valid;
    logic [4:0]  write_reg;
    logic [31:0] write_data, fwd_data1, fwd_data2, retired_cnt;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .reg_write_in(reg_write_in), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .load_type(load_type), .rt(rt), .rd(rd), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .read_reg1(read_reg1),
        .read_reg2(read_reg2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .wb_valid(wb_valid),
        .retired_cnt(retired_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && reg_write) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected none",
                         write_reg, write_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_reg", 32'(write_reg), 32'(e.r));
                chk("write_data", write_data, e.d);
            end
        end
    end

    // Present one entry for one capture edge; returns #1 after that edge.
    task automatic issue(input logic rwi, input logic [1:0] dst, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [4:0] t, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] mrd, input logic [31:0] pc4,
                         input bit expect_wr, input logic [4:0] er, input logic [31:0] ed);
        exp_t e;
        reg_write_in = rwi; reg_dst = dst; wb_sel = sel; load_type = lt;
        rt = t; rd = d; alu_result = alu; mem_rdata = mrd; pc_plus4 = pc4;
        in_valid = 1'b1;
        if (expect_wr) begin
            e.r = er; e.d = ed;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; reg_write_in = 1'b0;
        reg_dst = 2'b00; wb_sel = 2'b00; load_type = 3'b000; rt = '0; rd = '0;
        alu_result = '0; mem_rdata = '0; pc_plus4 = '0;
        read_reg1 = '0; read_reg2 = '0; rf_data1 = '0; rf_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);
        rst = 1'b0;

        // Back-to-back: ALU, loads, JAL, $0 target.
        issue(1, 2'b01, 2'b00, 3'b000, 5'd2, 5'd5, 32'h1234, 32'h0, 32'h0, 1, 5'd5, 32'h1234);
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        issue(1, 2'b00, 2'b01, 3'b001, 5'd3, 5'd0, 32'h3, 32'h80FF7F01, 32'h0, 1, 5'd3, 32'hFFFFFF80);
        issue(1, 2'b00, 2'b01, 3'b010, 5'd4, 5'd0, 32'h3, 32'h80FF7F01, 32'h0, 1, 5'd4, 32'h00000080);
        issue(1, 2'b00, 2'b01, 3'b011, 5'd6, 5'd0, 32'h2, 32'h80FF7F01, 32'h0, 1, 5'd6, 32'hFFFF80FF);
        issue(1, 2'b00, 2'b01, 3'b100, 5'd8, 5'd0, 32'h0, 32'h80FF7F01, 32'h0, 1, 5'd8, 32'h00007F01);
        issue(1, 2'b00, 2'b01, 3'b001, 5'd9, 5'd0, 32'h1, 32'h80FF7F01, 32'h0, 1, 5'd9, 32'h0000007F);
        issue(1, 2'b00, 2'b01, 3'b011, 5'd10, 5'd0, 32'h3, 32'h80FF7F01, 32'h0, 1, 5'd10, 32'hFFFF80FF);
        issue(1, 2'b11, 2'b01, 3'b111, 5'd11, 5'd1, 32'h2, 32'h80FF7F01, 32'h0, 1, 5'd11, 32'h80FF7F01);
        issue(1, 2'b10, 2'b10, 3'b000, 5'd1, 5'd2, 32'h0, 32'h0, 32'h400010, 1, 5'd31, 32'h400010);
        chk("alu_cnt", retired_cnt, 32'd8);
        issue(1, 2'b00, 2'b00, 3'b000, 5'd0, 5'd7, 32'hDEAD, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        chk("r0_reg_write", 32'(reg_write), 32'd0);
        chk("r0_wb_valid", 32'(wb_valid), 32'd1);
        @(posedge clk); #1;
        chk("burst_cnt", retired_cnt, 32'd10);
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);

        // Stall three cycles: one write, one retire.
        issue(1, 2'b01, 2'b00, 3'b000, 5'd0, 5'd9, 32'hCAFE, 32'h0, 32'h0, 1, 5'd9, 32'hCAFE);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_wb_valid", 32'(wb_valid), 32'd1);
        chk("stall_reg_write", 32'(reg_write), 32'd0);
        stall = 1'b0;
        @(posedge clk); #1;
        chk("stall_cnt", retired_cnt, 32'd11);

        // Flush with stall: entry dropped, not retired.
        issue(0, 2'b01, 2'b00, 3'b000, 5'd0, 5'd10, 32'h77, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        flush = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; stall = 1'b0;
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_cnt", retired_cnt, 32'd11);

        // Forwarding for a same-cycle read of the write target.
        issue(1, 2'b01, 2'b00, 3'b000, 5'd0, 5'd7, 32'h55AA, 32'h0, 32'h0, 1, 5'd7, 32'h55AA);
        read_reg1 = 5'd7; rf_data1 = 32'h0; read_reg2 = 5'd8; rf_data2 = 32'h1111;
        #1;
`ifdef WB_BYPASS_EN
        chk("fwd_data1", fwd_data1, 32'h55AA);
`else
        chk("fwd_data1", fwd_data1, 32'h0);
`endif
        chk("fwd_data2", fwd_data2, 32'h1111);
        @(posedge clk); #1;
        chk("fwd_cnt", retired_cnt, 32'd12);

        // Reset while stalled clears everything.
        issue(1, 2'b01, 2'b00, 3'b000, 5'd0, 5'd12, 32'hBEEF, 32'h0, 32'h0, 1, 5'd12, 32'hBEEF);
        stall = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        chk("rst_stall_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_stall_cnt", retired_cnt, 32'd0);
        chk("rst_stall_reg_write", 32'(reg_write), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
